// File: rtl/hc374_bus_reader_if.sv
// Bus-reader bundle: scan request, device strobes/enables, shared bus and byte handshake.
// The reader drives the master side; the devices and the downstream consumer sit on the slave side.
interface hc374_bus_reader_if #(
  parameter int N_DEV = 4
);
  logic             start;
  logic             cap;
  logic [N_DEV-1:0] one;
  logic [7:0]       bus;
  logic [7:0]       dout;
  logic [2:0]       dsel;
  logic             dvalid;
  logic             dready;
  logic             busy;
  logic             ovr;

  modport master (
    input  start, bus, dready,
    output cap, one, dout, dsel, dvalid, busy, ovr
  );

  modport slave (
    output start, bus, dready,
    input  cap, one, dout, dsel, dvalid, busy, ovr
  );
endinterface

// File: rtl/hc374_bus_reader.sv
// Scan controller for octal tri-state latches sharing one 8-bit bus: capture strobe,
// one-at-a-time output enable with settle time, byte delivery over valid/ready.
module hc374_bus_reader #(
  parameter int N_DEV  = 4,
  parameter int SETTLE = 2,
  parameter int TURN   = 1
) (
  input logic                clk,
  input logic                rst,
  hc374_bus_reader_if.master rdr
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ENABLE  = 3'd3,
    ST_VALID   = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  localparam logic [N_DEV-1:0] ALL_OFF     = {N_DEV{1'b1}};
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [3:0]       TURN_LOAD   = (TURN > 0) ? 4'(TURN - 1) : 4'd0;
  localparam logic [2:0]       LAST_IDX    = 3'(N_DEV - 1);

  state_t           state_r;
  logic [2:0]       idx_r;
  logic [3:0]       cnt_r;
  logic             cap_r;
  logic [N_DEV-1:0] one_r;
  logic [7:0]       dout_r;
  logic [2:0]       dsel_r;
  logic             dvalid_r;
  logic             busy_r;
  logic             ovr_r;

  // Active-low enable pattern with only the selected device driving the bus.
  function automatic logic [N_DEV-1:0] enable_mask(input logic [2:0] dev);
    logic [N_DEV-1:0] mask;
    mask = ALL_OFF;
    for (int k = 0; k < N_DEV; k++) begin
      if (3'(k) == dev) mask[k] = 1'b0;
    end
    return mask;
  endfunction

  // Scan sequencer; the async reset also releases the bus at once through one_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= 3'd0;
      cnt_r    <= 4'd0;
      cap_r    <= 1'b0;
      one_r    <= ALL_OFF;
      dout_r   <= 8'h00;
      dsel_r   <= 3'd0;
      dvalid_r <= 1'b0;
      busy_r   <= 1'b0;
      ovr_r    <= 1'b0;
    end else begin
      if (rdr.start && busy_r) ovr_r <= 1'b1;

      case (state_r)
        ST_IDLE: begin
          one_r <= ALL_OFF;
          if (rdr.start) begin
            state_r <= ST_CAPTURE;
            busy_r  <= 1'b1;
            cap_r   <= 1'b1;
            idx_r   <= 3'd0;
          end
        end
        ST_CAPTURE: begin
          cap_r   <= 1'b0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          state_r <= ST_ENABLE;
          one_r   <= enable_mask(idx_r);
          cnt_r   <= SETTLE_LOAD;
        end
        ST_ENABLE: begin
          // BUS is looked at only on this edge, so idle/undriven values never reach DOUT.
          if (cnt_r == 4'd0) begin
            dout_r   <= rdr.bus;
            dsel_r   <= idx_r;
            dvalid_r <= 1'b1;
            one_r    <= ALL_OFF;
            state_r  <= ST_VALID;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_VALID: begin
          if (rdr.dready) begin
            dvalid_r <= 1'b0;
            if (idx_r == LAST_IDX) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else if (TURN > 0) begin
              idx_r   <= idx_r + 3'd1;
              cnt_r   <= TURN_LOAD;
              state_r <= ST_GAP;
            end else begin
              idx_r   <= idx_r + 3'd1;
              one_r   <= enable_mask(idx_r + 3'd1);
              cnt_r   <= SETTLE_LOAD;
              state_r <= ST_ENABLE;
            end
          end
        end
        ST_GAP: begin
          if (cnt_r == 4'd0) begin
            one_r   <= enable_mask(idx_r);
            cnt_r   <= SETTLE_LOAD;
            state_r <= ST_ENABLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          cap_r    <= 1'b0;
          one_r    <= ALL_OFF;
          dvalid_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign rdr.cap    = cap_r;
  assign rdr.one    = one_r;
  assign rdr.dout   = dout_r;
  assign rdr.dsel   = dsel_r;
  assign rdr.dvalid = dvalid_r;
  assign rdr.busy   = busy_r;
  assign rdr.ovr    = ovr_r;

endmodule

// File: tb/tb_hc374_bus_reader.sv
// Directed bench for hc374_bus_reader: default timing, backpressure, overrun, async reset,
// parameter corners (SETTLE 1/15, TURN 0/7, N_DEV 1) with per-cycle bus-safety monitors.
module tb_hc374_bus_reader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_d = 1'b0, dready_d = 1'b0;
  logic start_ab = 1'b0, dready_ab = 1'b0;
  logic start_s = 1'b0, dready_s = 1'b0;

  int errors = 0;
  int checks = 0;

  hc374_bus_reader_if #(.N_DEV(4)) d_if ();
  hc374_bus_reader_if #(.N_DEV(4)) a_if ();
  hc374_bus_reader_if #(.N_DEV(4)) b_if ();
  hc374_bus_reader_if #(.N_DEV(1)) s_if ();

  hc374_bus_reader #(.N_DEV(4), .SETTLE(2),  .TURN(1)) u_dut (.clk(clk), .rst(rst), .rdr(d_if.master));
  hc374_bus_reader #(.N_DEV(4), .SETTLE(1),  .TURN(0)) u_fast (.clk(clk), .rst(rst), .rdr(a_if.master));
  hc374_bus_reader #(.N_DEV(4), .SETTLE(15), .TURN(7)) u_slow (.clk(clk), .rst(rst), .rdr(b_if.master));
  hc374_bus_reader #(.N_DEV(1), .SETTLE(2),  .TURN(0)) u_single (.clk(clk), .rst(rst), .rdr(s_if.master));

  always #5 clk = ~clk;

  // Device model: device k drives 0xA0+k while its enable is low, otherwise the bus floats.
  function automatic logic [7:0] bus_of(input logic [7:0] one_n);
    logic [7:0] v;
    v = 8'hzz;
    for (int k = 0; k < 8; k++) begin
      if (!one_n[k]) v = 8'hA0 + 8'(k);
    end
    return v;
  endfunction

  assign d_if.start = start_d;   assign d_if.dready = dready_d;  assign d_if.bus = bus_of({4'hF, d_if.one});
  assign a_if.start = start_ab;  assign a_if.dready = dready_ab; assign a_if.bus = bus_of({4'hF, a_if.one});
  assign b_if.start = start_ab;  assign b_if.dready = dready_ab; assign b_if.bus = bus_of({4'hF, b_if.one});
  assign s_if.start = start_s;   assign s_if.dready = dready_s;  assign s_if.bus = bus_of({7'h7F, s_if.one});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int contention_err(input logic [7:0] now, input logic [7:0] prev, input logic dv);
    int e;
    e = 0;
    if ($countones(now) > 1) e++;
    if (now != 8'h00 && prev != 8'h00 && now != prev) e++;
    if (dv && now != 8'h00) e++;
    return e;
  endfunction

  function automatic logic [2:0] low_index(input logic [7:0] now);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (now[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  function automatic int byte_err(input logic hs, input logic [7:0] dout, input logic [2:0] dsel,
                                  input logic [2:0] last, input logic [2:0] exp_idx);
    int e;
    e = 0;
    if (hs) begin
      if (dout !== 8'hA0 + {5'b00000, last}) e++;
      if (dsel !== last) e++;
      if (dsel !== exp_idx) e++;
    end
    return e;
  endfunction

  logic [7:0] low_d, low_a, low_b, low_s;
  assign low_d = {4'h0, ~d_if.one};
  assign low_a = {4'h0, ~a_if.one};
  assign low_b = {4'h0, ~b_if.one};
  assign low_s = {7'h00, ~s_if.one};

  logic [7:0] prev_d = 8'h00, prev_a = 8'h00, prev_b = 8'h00, prev_s = 8'h00;
  logic [2:0] last_d = 3'd0, last_a = 3'd0, last_b = 3'd0, last_s = 3'd0;
  logic [2:0] exp_d = 3'd0, exp_a = 3'd0, exp_b = 3'd0;
  int viol_d = 0, viol_a = 0, viol_b = 0, viol_s = 0;
  int hs_d = 0, hs_a = 0, hs_b = 0, hs_s = 0;

  // Safety/identity monitor for the default instance.
  always @(negedge clk) begin
    if (rst) begin
      prev_d <= 8'h00; exp_d <= 3'd0;
    end else begin
      viol_d <= viol_d + contention_err(low_d, prev_d, d_if.dvalid)
                + byte_err(d_if.dvalid && d_if.dready, d_if.dout, d_if.dsel, last_d, exp_d);
      prev_d <= low_d;
      if (low_d != 8'h00) last_d <= low_index(low_d);
      if (d_if.dvalid && d_if.dready) begin
        hs_d  <= hs_d + 1;
        exp_d <= (exp_d == 3'd3) ? 3'd0 : exp_d + 3'd1;
      end
    end
  end

  // Safety/identity monitor for the SETTLE=1, TURN=0 instance.
  always @(negedge clk) begin
    if (rst) begin
      prev_a <= 8'h00; exp_a <= 3'd0;
    end else begin
      viol_a <= viol_a + contention_err(low_a, prev_a, a_if.dvalid)
                + byte_err(a_if.dvalid && a_if.dready, a_if.dout, a_if.dsel, last_a, exp_a);
      prev_a <= low_a;
      if (low_a != 8'h00) last_a <= low_index(low_a);
      if (a_if.dvalid && a_if.dready) begin
        hs_a  <= hs_a + 1;
        exp_a <= (exp_a == 3'd3) ? 3'd0 : exp_a + 3'd1;
      end
    end
  end

  // Safety/identity monitor for the SETTLE=15, TURN=7 instance.
  always @(negedge clk) begin
    if (rst) begin
      prev_b <= 8'h00; exp_b <= 3'd0;
    end else begin
      viol_b <= viol_b + contention_err(low_b, prev_b, b_if.dvalid)
                + byte_err(b_if.dvalid && b_if.dready, b_if.dout, b_if.dsel, last_b, exp_b);
      prev_b <= low_b;
      if (low_b != 8'h00) last_b <= low_index(low_b);
      if (b_if.dvalid && b_if.dready) begin
        hs_b  <= hs_b + 1;
        exp_b <= (exp_b == 3'd3) ? 3'd0 : exp_b + 3'd1;
      end
    end
  end

  // Safety/identity monitor for the single-device instance.
  always @(negedge clk) begin
    if (rst) begin
      prev_s <= 8'h00;
    end else begin
      viol_s <= viol_s + contention_err(low_s, prev_s, s_if.dvalid)
                + byte_err(s_if.dvalid && s_if.dready, s_if.dout, s_if.dsel, last_s, 3'd0);
      prev_s <= low_s;
      if (low_s != 8'h00) last_s <= low_index(low_s);
      if (s_if.dvalid && s_if.dready) hs_s <= hs_s + 1;
    end
  end

  task automatic wait_idle_d(input string tag);
    for (int n = 0; n < 60 && d_if.busy; n++) @(negedge clk);
    check(tag, d_if.busy, 1'b0);
  endtask

  // Directed sequence.
  initial begin
    logic [31:0] cap_v, one0_v, dv_v, busy_v;
    int nb, fdv_a, fall_a, fdv_b, fall_b;
    logic found, done;
    int bad;

    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_one", d_if.one, 4'hF);
    check("rst_cap", d_if.cap, 1'b0);
    check("rst_dout", d_if.dout, 8'h00);
    check("rst_dsel", d_if.dsel, 3'd0);
    check("rst_dvalid", d_if.dvalid, 1'b0);
    check("rst_busy", d_if.busy, 1'b0);
    check("rst_ovr", d_if.ovr, 1'b0);
    check("rst_one_single", s_if.one, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Default scan, DREADY held high.
    #1 dready_d = 1'b1; start_d = 1'b1;
    cap_v = '0; one0_v = '0; dv_v = '0; busy_v = '0; nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cap_v[c] = d_if.cap; one0_v[c] = d_if.one[0]; dv_v[c] = d_if.dvalid; busy_v[c] = d_if.busy;
      if (d_if.dvalid) begin
        check("main_dv_cycle", c, 5 + 4 * nb);
        check("main_dout", d_if.dout, 8'hA0 + 8'(nb));
        check("main_dsel", d_if.dsel, 3'(nb));
        nb++;
      end
      if (c == 0) begin @(posedge clk); #1 start_d = 1'b0; end
    end
    check("main_cap_vec", cap_v, 32'h0000_0002);
    check("main_one0_vec", one0_v, 32'h000F_FFE7);
    check("main_dvalid_vec", dv_v, 32'h0002_2220);
    check("main_busy_vec", busy_v, 32'h0003_FFFE);
    check("main_nbytes", nb, 4);
    check("main_ovr", d_if.ovr, 1'b0);

    // Backpressure: DREADY low for ten cycles from the first DVALID.
    @(posedge clk); #1 dready_d = 1'b0; start_d = 1'b1;
    @(posedge clk); #1 start_d = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (d_if.dvalid) found = 1'b1;
    end
    check("bp_dvalid_seen", found, 1'b1);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      if (d_if.dout !== 8'hA0 || d_if.dsel !== 3'd0 || d_if.one !== 4'hF || d_if.dvalid !== 1'b1) bad++;
    end
    check("bp_stable_cycles_bad", bad, 0);
    @(posedge clk); #1 dready_d = 1'b1;
    @(negedge clk);
    check("bp_hs_one", d_if.one, 4'hF);
    check("bp_hs_dvalid", d_if.dvalid, 1'b1);
    @(negedge clk);
    check("bp_gap_one", d_if.one, 4'hF);
    check("bp_gap_dvalid", d_if.dvalid, 1'b0);
    @(negedge clk);
    check("bp_next_enable", d_if.one, 4'hD);
    wait_idle_d("bp_idle");

    // START mid-scan and in the final handshake cycle.
    @(posedge clk); #1 start_d = 1'b1;
    cap_v = '0; dv_v = '0; busy_v = '0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      cap_v[c] = d_if.cap; dv_v[c] = d_if.dvalid; busy_v[c] = d_if.busy;
      if (c == 3) check("ovr_before", d_if.ovr, 1'b0);
      if (c == 4) check("ovr_after", d_if.ovr, 1'b1);
      if (c == 0 || c == 2 || c == 3 || c == 16 || c == 17) begin
        @(posedge clk); #1 start_d = (c == 2 || c == 16);
      end
    end
    check("ovr_cap_vec", cap_v, 32'h0000_0002);
    check("ovr_dvalid_vec", dv_v, 32'h0002_2220);
    check("ovr_busy_vec", busy_v, 32'h0003_FFFE);
    @(posedge clk); #1 start_d = 1'b1;
    @(negedge clk);
    check("restart_cap_pre", d_if.cap, 1'b0);
    @(posedge clk); #1 start_d = 1'b0;
    @(negedge clk);
    check("restart_cap", d_if.cap, 1'b1);
    check("restart_busy", d_if.busy, 1'b1);

    // Asynchronous reset while device 2 drives the bus.
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (d_if.one === 4'hB) found = 1'b1;
    end
    check("arst_dev2_seen", found, 1'b1);
    check("arst_ovr_sticky", d_if.ovr, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_one", d_if.one, 4'hF);
    check("arst_dvalid", d_if.dvalid, 1'b0);
    check("arst_busy", d_if.busy, 1'b0);
    check("arst_ovr", d_if.ovr, 1'b0);
    @(posedge clk); #1 rst = 1'b0; start_d = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) check("fresh_one0", d_if.one, 4'hE);
      if (c == 5) begin
        check("fresh_dvalid", d_if.dvalid, 1'b1);
        check("fresh_dout", d_if.dout, 8'hA0);
        check("fresh_dsel", d_if.dsel, 3'd0);
      end
      if (c == 0) begin @(posedge clk); #1 start_d = 1'b0; end
    end
    wait_idle_d("fresh_idle");

    // Parameter corners: timing with DREADY high.
    @(posedge clk); #1 dready_ab = 1'b1; start_ab = 1'b1;
    fdv_a = -1; fall_a = -1; fdv_b = -1; fall_b = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (a_if.dvalid && fdv_a < 0) fdv_a = c;
      if (b_if.dvalid && fdv_b < 0) fdv_b = c;
      if (c > 1 && !a_if.busy && fall_a < 0) fall_a = c;
      if (c > 1 && !b_if.busy && fall_b < 0) fall_b = c;
      if (c == 0) begin @(posedge clk); #1 start_ab = 1'b0; end
    end
    check("fast_first_dvalid", fdv_a, 4);
    check("fast_busy_fall", fall_a, 11);
    check("slow_first_dvalid", fdv_b, 18);
    check("slow_busy_fall", fall_b, 88);

    // Parameter corners: random DREADY backpressure.
    @(posedge clk); #1 start_ab = 1'b1; dready_ab = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 800 && !done; n++) begin
      @(posedge clk); #1 start_ab = 1'b0; dready_ab = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (n > 2 && !a_if.busy && !b_if.busy) done = 1'b1;
    end
    check("corner_random_done", done, 1'b1);

    // Single device, TURN=0; second START in the first idle cycle.
    @(posedge clk); #1 dready_s = 1'b1; start_s = 1'b1;
    cap_v = '0; dv_v = '0; busy_v = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      cap_v[c] = s_if.cap; dv_v[c] = s_if.dvalid; busy_v[c] = s_if.busy;
      if (c == 0 || c == 5 || c == 6) begin
        @(posedge clk); #1 start_s = (c == 5);
      end
    end
    check("single_cap_vec", cap_v, 32'h0000_0082);
    check("single_dvalid_vec", dv_v, 32'h0000_0820);
    check("single_busy_vec", busy_v, 32'h0000_0FBE);
    check("single_ovr", s_if.ovr, 1'b0);

    repeat (2) @(negedge clk);
    check("mon_viol_default", viol_d, 0);
    check("mon_viol_fast", viol_a, 0);
    check("mon_viol_slow", viol_b, 0);
    check("mon_viol_single", viol_s, 0);
    check("mon_bytes_default", hs_d, 18);
    check("mon_bytes_fast", hs_a, 8);
    check("mon_bytes_slow", hs_b, 8);
    check("mon_bytes_single", hs_s, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
